rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port (i_write_en_3/i_addr_3/i_write_data_3) between the
//  in-order writeback path (port A) and the long-latency unit result path (port B, divider/mul).
//  Port B results are buffered in a small FIFO and drained into idle write-port cycles. An
//  anti-starvation counter stalls writeback when needed. Source-register busy flags go to decode.
// PARAMETERS
//  DATA_WIDTH  64  register data width
//  REG_ADDR_W  5   register address width
//  DEPTH       4   port B FIFO entries (power of two, >=2)
//  MAX_WAIT    8   cycles a valid FIFO head may wait before forcing a writeback stall
// PORTS
//  i_clk        in   1           clock
//  i_arst       in   1           reset, synchronous, active-high
//  i_wb_we      in   1           port A write request (writeback stage)
//  i_wb_addr    in   REG_ADDR_W  port A destination
//  i_wb_data    in   DATA_WIDTH  port A data
//  o_wb_stall   out  1           port A blocked this cycle; writeback holds its request
//  i_lu_valid   in   1           port B result valid
//  o_lu_ready   out  1           port B accept (FIFO not full)
//  i_lu_addr    in   REG_ADDR_W  port B destination
//  i_lu_data    in   DATA_WIDTH  port B data
//  o_rf_we      out  1           register-file write enable
//  o_rf_addr    out  REG_ADDR_W  register-file write address
//  o_rf_data    out  DATA_WIDTH  register-file write data
//  i_rs1_addr   in   REG_ADDR_W  decode source 1
//  i_rs2_addr   in   REG_ADDR_W  decode source 2
//  o_rs1_busy   out  1           rs1 has a pending FIFO write; decode must stall
//  o_rs2_busy   out  1           rs2 has a pending FIFO write
//  o_rs1_byp_v  out  1           rs1 bypass valid (RF_ARB_BYPASS_EN only, else 0)
//  o_rs1_byp_d  out  DATA_WIDTH  rs1 bypass data (else 0)
//  o_rs2_byp_v  out  1           rs2 bypass valid (RF_ARB_BYPASS_EN only, else 0)
//  o_rs2_byp_d  out  DATA_WIDTH  rs2 bypass data (else 0)
// BEHAVIOUR
//  - State: FIFO (valid/addr/data per entry, wrapping rd/wr pointers, count 0..DEPTH), wait counter.
//  - Reset: FIFO empty, count 0, wait counter 0. Outputs: o_wb_stall=0, o_lu_ready=1, busy/byp=0.
//    o_rf_* follows port A: with i_wb_we=0, all o_rf_* are 0.
//  - Write port mux, combinational, 0-cycle latency, priority per cycle:
//    1) force: head valid & wait==MAX_WAIT -> drain head, o_wb_stall=i_wb_we, wait<=0
//    2) i_wb_we & !force -> write A
//    3) FIFO non-empty -> drain head, wait<=0
//    4) else o_rf_we=0
//  - wait counter: increments each cycle a valid head is not drained; saturates at MAX_WAIT.
//  - Enqueue: i_lu_valid & o_lu_ready. o_lu_ready = count<DEPTH.
//    A drain in the same cycle does not raise ready (no full-FIFO pass-through).
//  - i_lu_addr==0: handshake completes, but no entry is written.
//  - WAW squash: port A is always younger than buffered B results. When A writes to addr X, every
//    FIFO entry with addr X is invalidated, including one enqueued in the same cycle.
//    An invalidated head is popped without asserting o_rf_we. It consumes the slot, but A still
//    wins that slot.
//  - Enqueue and drain in the same cycle: count is unchanged, pointers advance mod DEPTH.
//  - busy: OR over valid entries of (addr==rsN), with rsN!=0. Incoming port B data is not
//    compared.
//  - Reset mid-operation: all entries are discarded; in-flight port B results are lost. The
//    pipeline is reset with this block.
// CONFIGURATION
//  RF_ARB_BYPASS_EN defined: on a match, o_rsN_byp_v=1 and o_rsN_byp_d = data from the youngest
//    matching valid entry; o_rsN_busy=0 for that match.
//  RF_ARB_BYPASS_EN undefined: o_rsN_byp_v/d are tied 0; a match raises o_rsN_busy.
// TESTING
//  - Idle FIFO, A writes x5=0xAA -> same cycle o_rf_we=1, addr 5, data 0xAA; o_wb_stall=0.
//  - B enqueues x7=0x11 with A idle -> next cycle o_rf_we=1, addr 7; count returns to 0.
//  - Fill 4 B entries with A busy every cycle -> o_lu_ready=0; at wait==8 o_wb_stall=1 and head
//    drains.
//  - B x9 buffered, then A writes x9=0x3 -> entry squashed; x9 is never rewritten with the stale
//    value.
//  - B x3 buffered, i_rs1_addr=3 -> o_rs1_busy=1 (no macro), or byp_v=1 with B data (macro).
//  - Full FIFO, assert i_arst for 1 cycle -> count 0, o_lu_ready=1, no further o_rf_we.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between in-order writeback (A) and a buffered long-latency result path (B).
// Optional macro RF_ARB_BYPASS_EN: forward buffered B data to decode instead of raising busy.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_wb_stall,
  input  logic                  i_lu_valid,
  output logic                  o_lu_ready,
  input  logic [REG_ADDR_W-1:0] i_lu_addr,
  input  logic [DATA_WIDTH-1:0] i_lu_data,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_data,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rs1_byp_v,
  output logic [DATA_WIDTH-1:0] o_rs1_byp_d,
  output logic                  o_rs2_byp_v,
  output logic [DATA_WIDTH-1:0] o_rs2_byp_d
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wait_cnt;

  entry_t head;
  logic   non_empty, head_v, force_drain, wb_write, drain_v, pop, push;

  assign head        = fifo[rd_ptr];
  // Masked during reset so a stale head never reaches the register file.
  assign non_empty   = (count != '0) && !i_arst;
  assign head_v      = non_empty && head.vld;
  assign force_drain = head_v && (wait_cnt == WW'(MAX_WAIT));
  assign wb_write    = i_wb_we && !force_drain;
  assign drain_v     = head_v && (force_drain || !i_wb_we);
  // Squashed heads leave the queue without needing the write port.
  assign pop         = drain_v || (non_empty && !head.vld);
  assign o_lu_ready  = count < CW'(DEPTH);
  assign push        = i_lu_valid && o_lu_ready && (i_lu_addr != '0);
  assign o_wb_stall  = force_drain && i_wb_we;

  always_comb begin
    o_rf_we   = 1'b0;
    o_rf_addr = '0;
    o_rf_data = '0;
    if (drain_v) begin
      o_rf_we   = 1'b1;
      o_rf_addr = head.addr;
      o_rf_data = head.data;
    end else if (i_wb_we) begin
      o_rf_we   = 1'b1;
      o_rf_addr = i_wb_addr;
      o_rf_data = i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      // A is younger than every buffered B result: kill matching entries (WAW).
      for (int i = 0; i < DEPTH; i++)
        if (wb_write && fifo[i].vld && (fifo[i].addr == i_wb_addr)) fifo[i].vld <= 1'b0;
      if (pop) begin
        fifo[rd_ptr].vld <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        fifo[wr_ptr] <= '{vld: !(wb_write && (i_wb_addr == i_lu_addr)),
                          addr: i_lu_addr, data: i_lu_data};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (!head_v || drain_v)               wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT))   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  logic [DEPTH-1:0] m1, m2;
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign m1[g] = fifo[g].vld && (fifo[g].addr == i_rs1_addr) && (i_rs1_addr != '0);
    assign m2[g] = fifo[g].vld && (fifo[g].addr == i_rs2_addr) && (i_rs2_addr != '0);
  end

`ifdef RF_ARB_BYPASS_EN
  logic [PW-1:0] idx;
  always_comb begin
    idx         = '0;
    o_rs1_byp_d = '0;
    o_rs2_byp_d = '0;
    // Walk oldest to youngest so the youngest match wins.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (m1[idx]) o_rs1_byp_d = fifo[idx].data;
      if (m2[idx]) o_rs2_byp_d = fifo[idx].data;
    end
  end
  assign o_rs1_byp_v = |m1;
  assign o_rs2_byp_v = |m2;
  assign o_rs1_busy  = 1'b0;
  assign o_rs2_busy  = 1'b0;
`else
  assign o_rs1_busy  = |m1;
  assign o_rs2_busy  = |m2;
  assign o_rs1_byp_v = 1'b0;
  assign o_rs2_byp_v = 1'b0;
  assign o_rs1_byp_d = '0;
  assign o_rs2_byp_d = '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected RF writes queued at drive time, compared by a negedge monitor.
module tb_rf_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_stall;
  logic          lu_valid = 1'b0;
  logic          lu_ready;
  logic [AW-1:0] lu_addr = '0;
  logic [DW-1:0] lu_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] rs1 = '0, rs2 = '0;
  logic          rs1_busy, rs2_busy, rs1_bv, rs2_bv;
  logic [DW-1:0] rs1_bd, rs2_bd;

  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q [$];

  rf_write_arbiter dut (
    .i_clk(clk), .i_arst(rst),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_stall(wb_stall),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_addr(lu_addr), .i_lu_data(lu_data),
    .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_rs1_byp_v(rs1_bv), .o_rs1_byp_d(rs1_bd),
    .o_rs2_byp_v(rs2_bv), .o_rs2_byp_d(rs2_bd)
  );

  always #5 clk = ~clk;

  // Every RF write outside reset must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rf_write unexpected: got addr=%0d data=%h, required none", rf_addr, rf_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({rf_addr, rf_data} !== e) begin
          failures++;
          $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_addr, rf_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; lu_valid = 1'b0; wb_addr = '0; wb_data = '0; lu_addr = '0; lu_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++;
    if ({wb_stall, lu_ready, rf_we, rf_addr, rf_data, rs1_busy, rs2_busy, rs1_bv, rs2_bv} !==
        {1'b0, 1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 4'b0000}) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b ready=%b we=%b addr=%0d data=%h busy=%b%b byp=%b%b",
               wb_stall, lu_ready, rf_we, rf_addr, rf_data, rs1_busy, rs2_busy, rs1_bv, rs2_bv);
    end
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: we=%b ready=%b, required we=0 ready=1", rf_we, lu_ready);
    end
    next_cycle();
  endtask

  task automatic test_a_write();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'hAA;
    exp_q.push_back({5'd5, 64'hAA});
    @(negedge clk);
    checks++;
    if (wb_stall !== 1'b0 || rf_we !== 1'b1) begin
      failures++;
      $display("FAIL a_write: stall=%b we=%b, required stall=0 we=1", wb_stall, rf_we);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_b_single();
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 64'h11;
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL b_enqueue: ready=%b we=%b, required ready=1 we=0", lu_ready, rf_we);
    end
    next_cycle(); idle_inputs(); rs1 = 5'd7;
    exp_q.push_back({5'd7, 64'h11});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1) begin
      failures++;
      $display("FAIL b_drain: we=%b, required 1", rf_we);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs1_bv !== 1'b0) begin
      failures++;
      $display("FAIL b_empty_after: we=%b busy=%b byp=%b, required 0 0 0", rf_we, rs1_busy, rs1_bv);
    end
    rs1 = '0;
    next_cycle();
  endtask

  task automatic test_starvation();
    int n = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      wb_we = 1'b1; wb_addr = 5'd20; wb_data = 64'(100 + n);
      if (cyc < 4) begin
        lu_valid = 1'b1; lu_addr = 5'(10 + cyc); lu_data = 64'(32'h1000 + cyc);
      end else lu_valid = 1'b0;
      if (cyc == 9) exp_q.push_back({5'd10, 64'h1000});
      else begin
        exp_q.push_back({5'd20, 64'(100 + n)});
        n++;
      end
      @(negedge clk);
      checks++;
      if (wb_stall !== (cyc == 9)) begin
        failures++;
        $display("FAIL starve_stall cyc=%0d: stall=%b, required %b", cyc, wb_stall, cyc == 9);
      end
      if (cyc == 4) begin
        checks++;
        if (lu_ready !== 1'b0) begin
          failures++;
          $display("FAIL starve_full_ready: ready=%b, required 0", lu_ready);
        end
      end
      next_cycle();
    end
    idle_inputs();
    for (int k = 1; k < 4; k++) begin
      exp_q.push_back({5'(10 + k), 64'(32'h1000 + k)});
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1) begin
        failures++;
        $display("FAIL starve_drain k=%0d: we=%b, required 1", k, rf_we);
      end
      next_cycle();
    end
  endtask

  task automatic test_squash();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 64'h1;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 64'hDEAD;
    exp_q.push_back({5'd1, 64'h1});
    next_cycle();
    lu_valid = 1'b0; wb_addr = 5'd9; wb_data = 64'h3;
    exp_q.push_back({5'd9, 64'h3});
    next_cycle(); idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        failures++;
        $display("FAIL squash_idle k=%0d: we=%b addr=%0d, required we=0", k, rf_we, rf_addr);
      end
      next_cycle();
    end
    // Same-cycle enqueue and A write to the same register.
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 64'h4;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 64'hBEEF;
    exp_q.push_back({5'd9, 64'h4});
    next_cycle(); idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        failures++;
        $display("FAIL squash_same_cycle k=%0d: we=%b addr=%0d, required we=0", k, rf_we, rf_addr);
      end
      next_cycle();
    end
  endtask

  task automatic test_busy();
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 64'h22;
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 64'h55;
    exp_q.push_back({5'd2, 64'h22});
    next_cycle();
    wb_addr = 5'd4; wb_data = 64'h44; lu_data = 64'h66; rs1 = 5'd3; rs2 = 5'd3;
    exp_q.push_back({5'd4, 64'h44});
    @(negedge clk);
    checks++;
`ifdef RF_ARB_BYPASS_EN
    if ({rs1_busy, rs1_bv, rs2_bv} !== 3'b011 || rs1_bd !== 64'h55) begin
      failures++;
      $display("FAIL byp_one: busy=%b bv=%b%b bd=%h, required 0 11 55", rs1_busy, rs1_bv, rs2_bv, rs1_bd);
    end
`else
    if ({rs1_busy, rs2_busy, rs1_bv} !== 3'b110) begin
      failures++;
      $display("FAIL busy_one: busy=%b%b bv=%b, required 11 0", rs1_busy, rs2_busy, rs1_bv);
    end
`endif
    next_cycle();
    lu_valid = 1'b0; wb_data = 64'h45; rs2 = 5'd0;
    exp_q.push_back({5'd4, 64'h45});
    @(negedge clk);
    checks++;
`ifdef RF_ARB_BYPASS_EN
    if ({rs1_busy, rs1_bv, rs2_bv} !== 3'b010 || rs1_bd !== 64'h66) begin
      failures++;
      $display("FAIL byp_youngest: busy=%b bv=%b%b bd=%h, required 0 10 66", rs1_busy, rs1_bv, rs2_bv, rs1_bd);
    end
`else
    if ({rs1_busy, rs2_busy} !== 2'b10) begin
      failures++;
      $display("FAIL busy_rs0: busy=%b%b, required 10", rs1_busy, rs2_busy);
    end
`endif
    next_cycle(); idle_inputs();
    exp_q.push_back({5'd3, 64'h55});
    next_cycle();
    exp_q.push_back({5'd3, 64'h66});
    next_cycle();
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b0 || rs1_bv !== 1'b0) begin
      failures++;
      $display("FAIL busy_clear: busy=%b bv=%b, required 0 0", rs1_busy, rs1_bv);
    end
    rs1 = '0;
    next_cycle();
  endtask

  task automatic test_addr_zero();
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 64'h77;
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL addr0_ready: ready=%b, required 1", lu_ready);
    end
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL addr0_write: we=%b, required 0", rf_we);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc < 4; cyc++) begin
      wb_we = 1'b1; wb_addr = 5'd21; wb_data = 64'(cyc);
      lu_valid = 1'b1; lu_addr = 5'(10 + cyc); lu_data = 64'(cyc + 500);
      exp_q.push_back({5'd21, 64'(cyc)});
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: ready=%b, required 0", lu_ready);
    end
    rst = 1'b1;
    next_cycle(); rst = 1'b0; rs1 = 5'd10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || lu_ready !== 1'b1 || rs1_busy !== 1'b0 || rs1_bv !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset k=%0d: we=%b ready=%b busy=%b bv=%b, required 0 1 0 0",
                 k, rf_we, lu_ready, rs1_busy, rs1_bv);
      end
      next_cycle();
    end
    rs1 = '0;
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_single();
    test_starvation();
    test_squash();
    test_busy();
    test_addr_zero();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
